// File: rtl/hfu_pkg.sv
// Shared definitions for the hazard/forwarding unit: forwarding select codes,
// FSM state codes and the layout of one scoreboard entry.
package hfu_pkg;

  // EX operand select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB pipeline register
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM pipeline register

  // Load-use stall FSM
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hfu_state_e;

  // Bubble down-counter width; LOAD_STALL is at most 3
  localparam int BUB_W = 2;

  // Scoreboard entry layout: {rw[AW-1:0], valid, wr, load}
  localparam int SB_LOAD_W    = 1;
  localparam int SB_WR_W      = 1;
  localparam int SB_VALID_W   = 1;
  localparam int SB_CTRL_W    = SB_LOAD_W + SB_WR_W + SB_VALID_W;
  localparam int SB_LOAD_BIT  = 0;
  localparam int SB_WR_BIT    = 1;
  localparam int SB_VALID_BIT = 2;
  localparam int SB_RW_LSB    = 3;

endpackage

// File: rtl/hfu_stage_reg.sv
// One scoreboard entry. clear wins over load; an all-zero entry is invalid.
module hfu_stage_reg
  import hfu_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    clear,
  input  logic [AW+SB_CTRL_W-1:0] d,
  output logic [AW+SB_CTRL_W-1:0] q
);

  // Entry register: reset/clear to invalid, otherwise capture on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and EX operand forwarding for a 5-stage pipeline.
// A three-entry scoreboard (EX, MEM, WB) shadows the destinations in flight.
// Forward selects are computed while an instruction is in ID and registered,
// so they are valid during its EX cycle.
// Handshake: there is no valid/ready pair here; stall_id and bubble_ex are
// combinational requests in the current cycle, flush is an unconditional
// kill of the instruction entering EX and always overrides a stall.
module hazard_forward_unit
  import hfu_pkg::*;
#(
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16,
  parameter int ZERO_REG   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic [AW-1:0]    id_rw,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int EW = AW + SB_CTRL_W;

  logic [EW-1:0]    id_ent;
  logic [EW-1:0]    ex_ent;
  logic [EW-1:0]    mem_ent;
  // A WB producer never forwards (the regfile writes before it reads), so
  // nothing consumes this entry; it is kept to complete the scoreboard.
  logic [EW-1:0]    wb_unused_ent;

  logic             ex_valid, ex_wr, ex_load;
  logic [AW-1:0]    ex_rw;
  logic             mem_valid, mem_wr;
  logic [AW-1:0]    mem_rw;

  logic             hazard;
  logic             stall_req;
  logic             ex_clear;
  hfu_state_e       state, state_next;
  logic [BUB_W-1:0] bub_cnt, bub_next;
  logic [1:0]       sel_a, sel_b;

  // src is produced by a stage entry; register 0 is exempt when ZERO_REG=1
  function automatic logic match(input logic [AW-1:0] src, input logic v,
                                 input logic wr, input logic [AW-1:0] rw);
    return v & wr & (src == rw) & ~((ZERO_REG != 0) & (src == '0));
  endfunction

  // Pack the ID instruction into scoreboard entry layout
  always_comb begin
    id_ent                   = '0;
    id_ent[SB_LOAD_BIT]      = id_load;
    id_ent[SB_WR_BIT]        = id_wr;
    id_ent[SB_VALID_BIT]     = id_valid;
    id_ent[EW-1:SB_RW_LSB]   = id_rw;
  end

  assign ex_valid  = ex_ent[SB_VALID_BIT];
  assign ex_wr     = ex_ent[SB_WR_BIT];
  assign ex_load   = ex_ent[SB_LOAD_BIT];
  assign ex_rw     = ex_ent[EW-1:SB_RW_LSB];
  assign mem_valid = mem_ent[SB_VALID_BIT];
  assign mem_wr    = mem_ent[SB_WR_BIT];
  assign mem_rw    = mem_ent[EW-1:SB_RW_LSB];

  // A stalled or flushed ID slot enters EX as a bubble
  assign ex_clear = stall_req | flush;

  hfu_stage_reg #(.AW(AW)) u_ex (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .clear(ex_clear),
    .d(id_ent), .q(ex_ent)
  );

  hfu_stage_reg #(.AW(AW)) u_mem (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .clear(1'b0),
    .d(ex_ent), .q(mem_ent)
  );

  hfu_stage_reg #(.AW(AW)) u_wb (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .clear(1'b0),
    .d(mem_ent), .q(wb_unused_ent)
  );

  // Load in EX whose result the ID instruction needs
  assign hazard = id_valid & ex_load &
                  (match(id_rs, ex_valid, ex_wr, ex_rw) |
                   match(id_rt, ex_valid, ex_wr, ex_rw));

  // FSM state and bubble counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      bub_cnt <= '0;
    end else begin
      state   <= state_next;
      bub_cnt <= bub_next;
    end
  end

  // FSM next state: flush aborts any stall; extra bubbles only when LOAD_STALL>1
  always_comb begin
    state_next = state;
    bub_next   = bub_cnt;
    if (flush) begin
      state_next = ST_RUN;
      bub_next   = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (hazard && (LOAD_STALL > 1)) begin
            state_next = ST_STALL;
            bub_next   = BUB_W'(LOAD_STALL - 1);
          end
        end
        ST_STALL: begin
          bub_next = bub_cnt - BUB_W'(1);
          if (bub_cnt <= BUB_W'(1)) begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_RUN;
          bub_next   = '0;
        end
      endcase
    end
  end

  // FSM outputs: stall on a fresh hazard in RUN and on every STALL cycle
  always_comb begin
    stall_req = 1'b0;
    if (!flush) begin
      unique case (state)
        ST_RUN:   stall_req = hazard;
        ST_STALL: stall_req = 1'b1;
        default:  stall_req = 1'b0;
      endcase
    end
  end

  assign stall_id  = stall_req;
  assign bubble_ex = stall_req;

  // Operand selects for the ID instruction: newest non-load producer wins
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (match(id_rs, ex_valid, ex_wr, ex_rw) && !ex_load) begin
      sel_a = FWD_MEM;
    end else if (match(id_rs, mem_valid, mem_wr, mem_rw)) begin
      sel_a = FWD_WB;
    end
    if (match(id_rt, ex_valid, ex_wr, ex_rw) && !ex_load) begin
      sel_b = FWD_MEM;
    end else if (match(id_rt, mem_valid, mem_wr, mem_rw)) begin
      sel_b = FWD_WB;
    end
  end

  // Register selects so they line up with the EX cycle; bubbles read regfile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (ex_clear || !id_valid) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= sel_a;
      fwd_b <= sel_b;
    end
  end

  // Saturating count of cycles spent with ID held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_req && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
